sar_ctrl: RTL and testbench

- Successive-approximation control engine inside the SAR ADC macro, directly below the Wishbone-facing ADC wrapper.
- Takes a start-of-conversion request, drives the sample/hold switch and the capacitive-DAC code, and consumes the comparator decision bit by bit.
- Presents the finished code in a one-deep result register with a valid/read handshake for the register front-end.
- Supports single-shot and continuous conversion modes.

---
 rtl/sar_pkg.sv | 15 +
 rtl/sar_result_reg.sv | 36 +++
 rtl/sar_ctrl.sv | 136 +++++++++++++
 tb/tb_sar_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sar_pkg.sv
// Shared state encoding and default sizing for the SAR conversion engine.
package sar_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    CONV   = 2'd2,
    DONE   = 2'd3
  } sar_state_t;

  localparam int SAR_SIZE   = 8;
  localparam int SAR_SMPL_W = 4;
  localparam int SAR_IDX_W  = $clog2(SAR_SIZE);

endpackage

// File: rtl/sar_result_reg.sv
// One-deep capture register with valid/read handshake and sticky overrun flag.
module sar_result_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             overrun
);

  // A write beats a same-cycle read; a read always clears overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (wr) begin
        data  <= wr_data;
        valid <= 1'b1;
      end else if (rd) begin
        valid <= 1'b0;
      end
      if (rd) begin
        overrun <= 1'b0;
      end else if (wr && valid) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sar_ctrl.sv
// Successive-approximation engine: sample phase, one bit per clock, result capture.
module sar_ctrl
  import sar_pkg::*;
#(
  parameter int SIZE   = SAR_SIZE,
  parameter int SMPL_W = SAR_SMPL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              soc,
  input  logic              cont,
  input  logic [SMPL_W-1:0] smpl_cycles,
  input  logic              cmp,
  output logic              sample_n,
  output logic [SIZE-1:0]   dac_code,
  output logic              busy,
  output logic              eoc,
  output logic [SIZE-1:0]   data,
  output logic              data_valid,
  input  logic              data_rd,
  output logic              overrun
);

  localparam int               IDX_W    = $clog2(SIZE);
  localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(SIZE - 1);
  localparam logic [SIZE-1:0]  MSB_CODE = {1'b1, {(SIZE-1){1'b0}}};

  sar_state_t        state, state_nx;
  logic [SMPL_W-1:0] cnt, cnt_nx, smpl_load;
  logic [IDX_W-1:0]  idx, idx_nx;
  logic [SIZE-1:0]   code_nx, trial;
  logic              sample_nx, eoc_nx, wr;

  assign smpl_load = (smpl_cycles == '0) ? SMPL_W'(1) : smpl_cycles;

  // Resolve the current bit from the comparator and arm the next lower trial bit.
  always_comb begin
    trial      = dac_code;
    trial[idx] = cmp;
    if (idx != '0) begin
      trial[idx - IDX_W'(1)] = 1'b1;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    idx_nx    = idx;
    code_nx   = dac_code;
    sample_nx = sample_n;
    eoc_nx    = 1'b0;
    wr        = 1'b0;
    case (state)
      IDLE: begin
        if (soc) begin
          state_nx  = SAMPLE;
          cnt_nx    = smpl_load;
          sample_nx = 1'b0;
        end
      end
      SAMPLE: begin
        if (cnt <= SMPL_W'(1)) begin
          state_nx  = CONV;
          sample_nx = 1'b1;
          code_nx   = MSB_CODE;
          idx_nx    = IDX_MSB;
        end else begin
          cnt_nx = cnt - SMPL_W'(1);
        end
      end
      CONV: begin
        code_nx = trial;
        if (idx == '0) begin
          state_nx = DONE;
          eoc_nx   = 1'b1;
          wr       = 1'b1;
        end else begin
          idx_nx = idx - IDX_W'(1);
        end
      end
      DONE: begin
        if (cont) begin
          state_nx  = SAMPLE;
          cnt_nx    = smpl_load;
          sample_nx = 1'b0;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    // Disable aborts from any state without producing a result.
    if (!en) begin
      state_nx  = IDLE;
      sample_nx = 1'b1;
      code_nx   = '0;
      eoc_nx    = 1'b0;
      wr        = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      dac_code <= '0;
      sample_n <= 1'b1;
      busy     <= 1'b0;
      eoc      <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      idx      <= idx_nx;
      dac_code <= code_nx;
      sample_n <= sample_nx;
      busy     <= (state_nx != IDLE);
      eoc      <= eoc_nx;
    end
  end

  sar_result_reg #(
    .WIDTH(SIZE)
  ) u_result (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr      (wr),
    .wr_data (trial),
    .rd      (data_rd),
    .data    (data),
    .valid   (data_valid),
    .overrun (overrun)
  );

endmodule

// File: tb/tb_sar_ctrl.sv
// Self-checking bench for sar_ctrl: event-level conversion model plus directed literal checks.
module tb_sar_ctrl;

  localparam int SIZE   = 8;
  localparam int SMPL_W = 4;

  logic              clk, rst_n, en, soc, cont, cmp, data_rd;
  logic [SMPL_W-1:0] smpl_cycles;
  logic              sample_n, busy, eoc, data_valid, overrun;
  logic [SIZE-1:0]   dac_code, data;
  logic [SIZE-1:0]   vin;
  int                cmp_mode;
  bit                chk_on;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [SIZE-1:0] seq_q[$];
  logic [SIZE-1:0] exp_seq[8] = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};

  sar_ctrl #(.SIZE(SIZE), .SMPL_W(SMPL_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .soc        (soc),
    .cont       (cont),
    .smpl_cycles(smpl_cycles),
    .cmp        (cmp),
    .sample_n   (sample_n),
    .dac_code   (dac_code),
    .busy       (busy),
    .eoc        (eoc),
    .data       (data),
    .data_valid (data_valid),
    .data_rd    (data_rd),
    .overrun    (overrun)
  );

  // Behavioural comparator; modes 1/2 tie the decision high/low.
  assign cmp = (cmp_mode == 1) ? 1'b1 : (cmp_mode == 2) ? 1'b0 : (vin >= dac_code);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a conversion is a count of edges since its start edge.
  bit m_active, m_valid, m_ovr, m_write;
  int m_p, m_s, m_vin, m_idle_dac, m_data;

  function automatic int trial_code(input int v, input int j);
    int hi;
    hi = (v >> (SIZE - j)) << (SIZE - j);
    return hi | (1 << (SIZE - 1 - j));
  endfunction

  function automatic void start_conv();
    m_active = 1'b1;
    m_p      = 0;
    m_s      = (smpl_cycles == '0) ? 1 : int'(smpl_cycles);
    m_vin    = int'(vin);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0; m_p = 0; m_s = 1; m_vin = 0; m_idle_dac = 0;
      m_data = 0; m_valid = 1'b0; m_ovr = 1'b0;
    end else begin
      m_write = 1'b0;
      if (!en) begin
        m_active   = 1'b0;
        m_idle_dac = 0;
      end else if (!m_active) begin
        if (soc) start_conv();
      end else if (m_p == m_s + SIZE) begin
        m_idle_dac = m_vin;
        if (cont) start_conv();
        else m_active = 1'b0;
      end else begin
        m_p++;
        m_write = (m_p == m_s + SIZE);
      end
      if (m_write) begin
        m_ovr   = !data_rd && (m_ovr || m_valid);
        m_valid = 1'b1;
        m_data  = m_vin;
      end else if (data_rd) begin
        m_valid = 1'b0;
        m_ovr   = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && chk_on) begin
      checkOutput("busy", busy, m_active);
      checkOutput("sample_n", sample_n, !(m_active && m_p < m_s));
      checkOutput("eoc", eoc, m_active && m_p == m_s + SIZE);
      if (!m_active)
        checkOutput("dac_idle", dac_code, m_idle_dac);
      else if (m_p >= m_s)
        checkOutput("dac_code", dac_code,
                    (m_p == m_s + SIZE) ? m_vin : trial_code(m_vin, m_p - m_s));
      checkOutput("data", data, m_data);
      checkOutput("data_valid", data_valid, m_valid);
      checkOutput("overrun", overrun, m_ovr);
    end
  end

  task automatic applyStimulus(input logic e, input logic s, input logic c, input logic r,
                               input int smpl, input int v, input int mode);
    @(negedge clk);
    en          = e;
    soc         = s;
    cont        = c;
    data_rd     = r;
    smpl_cycles = smpl[SMPL_W-1:0];
    vin         = v[SIZE-1:0];
    cmp_mode    = mode;
  endtask

  task automatic readResult();
    @(negedge clk);
    data_rd = 1'b1;
    @(negedge clk);
    data_rd = 1'b0;
  endtask

  // Single-shot conversion; k counts negedges after the soc edge.
  task automatic runSingle(input int v, input int mode, input int smpl,
                           input int exp_k, input int exp_data, input int exp_low);
    int eoc_k, low_cnt;
    seq_q.delete();
    eoc_k   = -1;
    low_cnt = 0;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, smpl, v, mode);
    @(posedge clk);
    for (int k = 0; k < 40 && eoc_k < 0; k++) begin
      @(negedge clk);
      soc = 1'b0;
      if (!sample_n) low_cnt++;
      if (busy && sample_n && !eoc) seq_q.push_back(dac_code);
      if (eoc) begin
        eoc_k = k;
        checkOutput("eoc_data", data, exp_data);
        checkOutput("eoc_valid", data_valid, 1);
      end
    end
    checkOutput("eoc_latency", eoc_k, exp_k);
    checkOutput("sample_low_cycles", low_cnt, exp_low);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; soc = 1'b0; cont = 1'b0; data_rd = 1'b0;
    smpl_cycles = '0; vin = '0; cmp_mode = 0; chk_on = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_sample_n", sample_n, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_dac", dac_code, 0);
    checkOutput("rst_eoc", eoc, 0);
    checkOutput("rst_data", data, 0);
    checkOutput("rst_valid", data_valid, 0);
    checkOutput("rst_overrun", overrun, 0);
    en = 1'b1;
    #2 rst_n = 1'b1;
    chk_on = 1'b1;

    runSingle(8'hA5, 0, 2, 10, 8'hA5, 2);
    checkOutput("seq_len", seq_q.size(), 8);
    for (int i = 0; i < 8 && i < seq_q.size(); i++)
      checkOutput($sformatf("seq_%0d", i), seq_q[i], exp_seq[i]);
    readResult();

    runSingle(8'hFF, 1, 2, 10, 8'hFF, 2);
    readResult();
    runSingle(8'h00, 2, 2, 10, 8'h00, 2);
    readResult();
    runSingle(8'h5A, 0, 0, 9, 8'h5A, 1);
    readResult();

    // Continuous mode: overrun on 2nd result, read coinciding with 3rd write.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 2, 8'h3C, 0);
    @(posedge clk);
    for (int k = 0; k <= 34; k++) begin
      @(negedge clk);
      soc = 1'b0;
      if (k == 10) begin
        checkOutput("cont_eoc1", eoc, 1);
        checkOutput("cont_ovr1", overrun, 0);
      end
      if (k == 21) begin
        checkOutput("cont_eoc2", eoc, 1);
        checkOutput("cont_ovr2", overrun, 1);
      end
      if (k == 31) data_rd = 1'b1;
      if (k == 32) begin
        data_rd = 1'b0;
        cont    = 1'b0;
        checkOutput("cont_eoc3", eoc, 1);
        checkOutput("cont_valid3", data_valid, 1);
        checkOutput("cont_ovr3", overrun, 0);
        checkOutput("cont_data3", data, 8'h3C);
      end
      if (k == 34) checkOutput("cont_stop_busy", busy, 0);
    end

    // Abort via en during the 4th conversion cycle; soc while busy is ignored.
    begin
      int eoc_seen;
      eoc_seen = 0;
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 2, 8'h5A, 0);
      @(posedge clk);
      for (int k = 0; k <= 14; k++) begin
        @(negedge clk);
        soc = (k == 3);
        if (k == 5) en = 1'b0;
        if (k == 6) begin
          checkOutput("abort_busy", busy, 0);
          checkOutput("abort_dac", dac_code, 0);
          checkOutput("abort_sample_n", sample_n, 1);
        end
        if (k == 7) en = 1'b1;
        if (eoc) eoc_seen++;
      end
      checkOutput("abort_no_eoc", eoc_seen, 0);
      checkOutput("abort_data_kept", data, 8'h3C);
      checkOutput("abort_valid_kept", data_valid, 1);
    end

    // Asynchronous reset in the middle of the sample phase.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4, 8'hC3, 0);
    @(posedge clk);
    @(negedge clk);
    soc = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_sample_n", sample_n, 1);
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_valid", data_valid, 0);
    checkOutput("arst_data", data, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    runSingle(8'h96, 0, 3, 11, 8'h96, 3);
    readResult();

    // Randomized traffic against the model.
    for (int n = 0; n < 800; n++) begin
      @(negedge clk);
      en          = ($urandom_range(0, 39) != 0);
      soc         = ($urandom_range(0, 3) == 0);
      cont        = ($urandom_range(0, 5) == 0);
      data_rd     = ($urandom_range(0, 4) == 0);
      smpl_cycles = SMPL_W'($urandom_range(0, 5));
      cmp_mode    = 0;
      if (!m_active) vin = SIZE'($urandom_range(0, 255));
    end
    @(negedge clk);
    en = 1'b0; soc = 1'b0; cont = 1'b0; data_rd = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
